// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, baud values, FSM state type and helpers
// Purpose: parity and baud-rate select encodings, baud values, TX state type,
//          divider and parity helper functions shared by the TX path.
package uart_pkg;

    // parity_type encodings (00 and 11 both mean "no parity")
    localparam logic [1:0] PAR_NONE    = 2'b00;
    localparam logic [1:0] PAR_ODD     = 2'b01;
    localparam logic [1:0] PAR_EVEN    = 2'b10;
    localparam logic [1:0] PAR_NONE_B  = 2'b11;

    // baud_rate encodings
    localparam logic [1:0] BAUD_SEL_2400  = 2'b00;
    localparam logic [1:0] BAUD_SEL_4800  = 2'b01;
    localparam logic [1:0] BAUD_SEL_9600  = 2'b10;
    localparam logic [1:0] BAUD_SEL_19200 = 2'b11;

    // baud values in bits per second
    localparam int BAUD_2400  = 2400;
    localparam int BAUD_4800  = 4800;
    localparam int BAUD_9600  = 9600;
    localparam int BAUD_19200 = 19200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Clock cycles per bit, rounded to nearest: round(clk_freq / baud)
    function automatic int baud_div(input int clk_freq, input logic [1:0] sel);
        int b;
        case (sel)
            BAUD_SEL_2400: b = BAUD_2400;
            BAUD_SEL_4800: b = BAUD_4800;
            BAUD_SEL_9600: b = BAUD_9600;
            default:       b = BAUD_19200;
        endcase
        return (clk_freq + b / 2) / b;
    endfunction

    // Parity bit for a data byte: odd -> ~^d, even -> ^d, none -> 1
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] ptype);
        case (ptype)
            PAR_ODD:  return ~^d;
            PAR_EVEN: return ^d;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// rtl/tx_baud_gen.sv - 1x bit-rate tick generator for the UART transmitter
// Purpose: emits a one-cycle bit_tick every DIV clocks, DIV = round(CLK_FREQ/baud).
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   clear     - holds the counter at 0 (asserted while the transmitter is idle)
//   baud_rate - latched baud select
//   bit_tick  - high for the last clock of each bit period
module tx_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] baud_rate,
    output logic       bit_tick
);

    localparam int DIV_2400  = baud_div(CLK_FREQ, BAUD_SEL_2400);
    localparam int DIV_4800  = baud_div(CLK_FREQ, BAUD_SEL_4800);
    localparam int DIV_9600  = baud_div(CLK_FREQ, BAUD_SEL_9600);
    localparam int DIV_19200 = baud_div(CLK_FREQ, BAUD_SEL_19200);
    // 2400 baud has the longest period, so it sizes the counter
    localparam int CNT_W     = $clog2(DIV_2400 + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_div_m1;

    always_comb begin
        w_div_m1 = CNT_W'(DIV_19200 - 1);
        case (baud_rate)
            BAUD_SEL_2400: w_div_m1 = CNT_W'(DIV_2400 - 1);
            BAUD_SEL_4800: w_div_m1 = CNT_W'(DIV_4800 - 1);
            BAUD_SEL_9600: w_div_m1 = CNT_W'(DIV_9600 - 1);
            default:       w_div_m1 = CNT_W'(DIV_19200 - 1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == w_div_m1) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (r_cnt == w_div_m1);

endmodule

// File: rtl/tx_unit.sv
// rtl/tx_unit.sv - UART transmitter: 11-bit frame, selectable parity and baud
// Purpose: on send in IDLE, latches the byte/parity/baud and shifts out
//          start, d0..d7, parity, stop, each bit held DIV clocks.
// Ports:
//   clk         - system clock
//   rst         - synchronous active-high reset (aborts a frame)
//   send        - transmit request, ignored while a frame is active
//   data_in     - byte to transmit
//   parity_type - 00/11 none, 01 odd, 10 even
//   baud_rate   - 00=2400, 01=4800, 10=9600, 11=19200
//   data_tx     - serial output, idle high
//   active_flag - high while a frame is in progress
//   done_flag   - one-cycle pulse at frame completion
module tx_unit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] data_in,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic       data_tx,
    output logic       active_flag,
    output logic       done_flag
);

    tx_state_t   r_state;
    logic [10:0] r_frame;     // PISO: bit 0 is the bit currently on the line
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_baud;
    logic        r_active;
    logic        r_done;
    logic        w_bit_tick;
    logic        w_clear;

    // Counter held at 0 in IDLE so the start bit always gets a full period
    assign w_clear = (r_state == ST_IDLE);

    tx_baud_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .baud_rate (r_baud),
        .bit_tick  (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_baud    <= '0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (send) begin
                    r_frame   <= {1'b1, parity_bit(data_in, parity_type), data_in, 1'b0};
                    r_baud    <= baud_rate;
                    r_bit_cnt <= '0;
                    r_active  <= 1'b1;
                    r_state   <= ST_START;
                end
            end else if (w_bit_tick) begin
                // every bit boundary shifts the next bit onto the line
                r_frame <= {1'b1, r_frame[10:1]};
                case (r_state)
                    ST_START:  r_state <= ST_DATA;
                    ST_DATA: begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: r_state <= ST_STOP;
                    ST_STOP: begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Line is forced high whenever no frame is active (idle, reset, abort)
    assign data_tx     = r_frame[0] | ~r_active;
    assign active_flag = r_active;
    assign done_flag   = r_done;

endmodule
